// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state encoding and bypass constants for the divide/HI-LO controller
package div_ctrl_pkg;
   typedef enum logic [2:0] {IDLE, ISSUE, WAIT, DRAIN, RESP} state_t;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] DIVZ_QUOT = 32'hFFFF_FFFF;
endpackage

// File: rtl/div_watchdog.sv
// div_watchdog: cycle counter that pulses expire on the MAX_CYC-th enabled cycle since clear
module div_watchdog #(
   parameter int MAX_CYC = 40
) (
   input  logic div_clk,
   input  logic reset,
   input  logic clr,
   input  logic en,
   output logic expire
);
   localparam int CW = $clog2(MAX_CYC + 1);
   logic [CW-1:0] cnt;
   always_ff @(posedge div_clk)
      if (reset || clr) cnt <= '0;
      else if (en) cnt <= cnt + 1'b1;
   assign expire = en && (cnt == CW'(MAX_CYC - 1));
endmodule

// File: rtl/div_hilo_ctrl.sv
// div_hilo_ctrl: issues divides to the iterative divider, commits results to HI/LO,
// bypasses divide-by-zero and signed overflow, and drains flushed divides.
module div_hilo_ctrl
   import div_ctrl_pkg::*;
#(
   parameter int DATA_W  = 32,
   parameter int MAX_CYC = 40
) (
   input  logic              div_clk,
   input  logic              reset,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_signed,
   input  logic [DATA_W-1:0] req_x,
   input  logic [DATA_W-1:0] req_y,
   input  logic              req_cancel,
   output logic              res_valid,
   input  logic              res_ready,
   output logic [DATA_W-1:0] res_quot,
   output logic [DATA_W-1:0] res_rem,
   output logic              busy,
   input  logic              mt_we_hi,
   input  logic              mt_we_lo,
   input  logic [DATA_W-1:0] mt_wdata,
   output logic [DATA_W-1:0] hi,
   output logic [DATA_W-1:0] lo,
   output logic              timeout_err,
   output logic              div_start,
   output logic              div_sgn,
   output logic [DATA_W-1:0] div_x,
   output logic [DATA_W-1:0] div_y,
   input  logic [DATA_W-1:0] div_s,
   input  logic [DATA_W-1:0] div_r,
   input  logic              div_complete
);
   state_t state, state_d;
   logic accept, load, commit, to, wd_clr, wd_exp, divz, ovf;
   logic [DATA_W-1:0] q_d, r_d;

   assign divz = req_y == '0;
   assign ovf  = req_signed && req_x == INT_MIN && req_y == DIVZ_QUOT;
   assign busy = state != IDLE;

   div_watchdog #(.MAX_CYC(MAX_CYC)) u_wd (
      .div_clk(div_clk), .reset(reset), .clr(wd_clr),
      .en(state == WAIT || state == DRAIN), .expire(wd_exp)
   );

   always_comb begin
      state_d   = state;
      req_ready = 1'b0;
      res_valid = 1'b0;
      div_start = 1'b0;
      accept    = 1'b0;
      load      = 1'b0;
      commit    = 1'b0;
      to        = 1'b0;
      wd_clr    = 1'b0;
      q_d       = div_s;
      r_d       = div_r;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            accept    = req_valid && !req_cancel;
            q_d       = divz ? DIVZ_QUOT : INT_MIN;
            r_d       = divz ? req_x : '0;
            if (accept) begin
               state_d = (divz || ovf) ? RESP : ISSUE;
               load    = divz || ovf;
               commit  = divz || ovf;
            end
         end
         ISSUE: begin
            div_start = 1'b1;
            wd_clr    = 1'b1;
            state_d   = WAIT;
         end
         WAIT:
            // completion beats a same-cycle flush: the result is already architectural
            if (div_complete) begin
               state_d = RESP;
               load    = 1'b1;
               commit  = 1'b1;
            end else if (req_cancel) begin
               state_d = DRAIN;
               wd_clr  = 1'b1;
            end else if (wd_exp) begin
               state_d = RESP;
               load    = 1'b1;
               to      = 1'b1;
               q_d     = '0;
               r_d     = '0;
            end
         DRAIN:
            if (div_complete || wd_exp) begin
               state_d = IDLE;
               to      = !div_complete;
            end
         RESP: begin
            res_valid = 1'b1;
            state_d   = res_ready ? IDLE : RESP;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge div_clk) begin
      if (reset) begin
         state       <= IDLE;
         div_x       <= '0;
         div_y       <= '0;
         div_sgn     <= 1'b0;
         res_quot    <= '0;
         res_rem     <= '0;
         hi          <= '0;
         lo          <= '0;
         timeout_err <= 1'b0;
      end else begin
         state <= state_d;
         if (accept) begin
            div_x   <= req_x;
            div_y   <= req_y;
            div_sgn <= req_signed;
         end
         if (load) begin
            res_quot <= q_d;
            res_rem  <= r_d;
         end
         if (to) timeout_err <= 1'b1;
         if (mt_we_hi) hi <= mt_wdata;
         else if (commit) hi <= r_d;
         if (mt_we_lo) lo <= mt_wdata;
         else if (commit) lo <= q_d;
      end
   end
endmodule

// File: tb/tb_div_hilo_ctrl.sv
// tb_div_hilo_ctrl: directed checks of div_hilo_ctrl against a behavioural divider with
// programmable latency (or no completion at all).
module tb_div_hilo_ctrl;
   logic        div_clk, reset;
   logic        req_valid, req_ready, req_signed, req_cancel;
   logic [31:0] req_x, req_y;
   logic        res_valid, res_ready, busy;
   logic [31:0] res_quot, res_rem;
   logic        mt_we_hi, mt_we_lo;
   logic [31:0] mt_wdata, hi, lo;
   logic        timeout_err, div_start, div_sgn, div_complete;
   logic [31:0] div_x, div_y, div_s, div_r;

   int vectors = 0, miscompares = 0;
   int lat = 33, cnt = 0, starts = 0;
   bit hang = 0;
   int waited;

   div_hilo_ctrl #(.DATA_W(32), .MAX_CYC(40)) dut (
      .div_clk(div_clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready), .req_signed(req_signed),
      .req_x(req_x), .req_y(req_y), .req_cancel(req_cancel),
      .res_valid(res_valid), .res_ready(res_ready), .res_quot(res_quot), .res_rem(res_rem),
      .busy(busy), .mt_we_hi(mt_we_hi), .mt_we_lo(mt_we_lo), .mt_wdata(mt_wdata),
      .hi(hi), .lo(lo), .timeout_err(timeout_err),
      .div_start(div_start), .div_sgn(div_sgn), .div_x(div_x), .div_y(div_y),
      .div_s(div_s), .div_r(div_r), .div_complete(div_complete)
   );

   initial div_clk = 1'b0;
   always #5 div_clk = ~div_clk;

   // behavioural divider: completes lat cycles after the start pulse unless hang is set
   always @(posedge div_clk) begin
      div_complete <= 1'b0;
      if (div_start) starts = starts + 1;
      if (reset) cnt <= 0;
      else if (div_start && !hang) cnt <= lat;
      else if (cnt != 0) begin
         cnt <= cnt - 1;
         if (cnt == 1) begin
            div_complete <= 1'b1;
            div_s <= div_sgn ? $signed(div_x) / $signed(div_y) : div_x / div_y;
            div_r <= div_sgn ? $signed(div_x) % $signed(div_y) : div_x % div_y;
         end
      end
   end

   task automatic tick;
      @(negedge div_clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic issue(input logic sgn, input logic [31:0] x, input logic [31:0] y);
      req_valid = 1'b1; req_signed = sgn; req_x = x; req_y = y;
      tick;
      req_valid = 1'b0;
   endtask

   task automatic consume;
      res_ready = 1'b1;
      tick;
      res_ready = 1'b0;
   endtask

   initial begin
      int s0;
      logic [31:0] q0, r0;
      reset = 1'b1; req_valid = 0; req_signed = 0; req_x = 0; req_y = 0; req_cancel = 0;
      res_ready = 0; mt_we_hi = 0; mt_we_lo = 0; mt_wdata = 0;
      div_s = 0; div_r = 0; div_complete = 0;
      tick; tick;
      chk("rst_hi", hi, 0);
      chk("rst_lo", lo, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_timeout", timeout_err, 0);
      chk("rst_req_ready", req_ready, 1);
      reset = 1'b0;
      tick;

      // 1: unsigned 100/7, 33-cycle divider
      lat = 33; s0 = starts;
      issue(0, 100, 7);
      chk("t1_start", div_start, 1);
      chk("t1_ready_low", req_ready, 0);
      tick;
      chk("t1_start_pulse", div_start, 0);
      for (waited = 0; waited < 80 && !res_valid; waited++) tick;
      chk("t1_res_valid", res_valid, 1);
      chk("t1_quot", res_quot, 14);
      chk("t1_rem", res_rem, 2);
      chk("t1_lo", lo, 14);
      chk("t1_hi", hi, 2);
      chk("t1_starts", starts - s0, 1);
      consume;
      chk("t1_busy", busy, 0);
      chk("t1_req_ready", req_ready, 1);

      // 2: signed overflow bypass
      s0 = starts;
      issue(1, 32'h8000_0000, 32'hFFFF_FFFF);
      chk("t2_res_valid", res_valid, 1);
      chk("t2_quot", res_quot, 32'h8000_0000);
      chk("t2_rem", res_rem, 0);
      chk("t2_lo", lo, 32'h8000_0000);
      chk("t2_hi", hi, 0);
      tick;
      chk("t2_no_start", starts - s0, 0);
      consume;

      // 3: divide by zero bypass
      issue(0, 5, 0);
      chk("t3_res_valid", res_valid, 1);
      chk("t3_quot", res_quot, 32'hFFFF_FFFF);
      chk("t3_rem", res_rem, 5);
      chk("t3_hi", hi, 5);
      chk("t3_lo", lo, 32'hFFFF_FFFF);
      consume;

      // 4: flush 10 cycles into WAIT, result discarded
      lat = 20;
      issue(0, 100, 7);
      tick;
      repeat (10) tick;
      req_cancel = 1'b1;
      tick;
      req_cancel = 1'b0;
      chk("t4_drain_busy", busy, 1);
      chk("t4_drain_not_ready", req_ready, 0);
      for (waited = 0; waited < 60 && !div_complete; waited++) tick;
      chk("t4_complete_seen", div_complete, 1);
      chk("t4_ready_before", req_ready, 0);
      tick;
      chk("t4_ready_after", req_ready, 1);
      chk("t4_res_valid", res_valid, 0);
      chk("t4_hi", hi, 5);
      chk("t4_lo", lo, 32'hFFFF_FFFF);

      // 5: divider never completes -> watchdog after 40 cycles in WAIT
      hang = 1;
      issue(0, 9, 2);
      for (waited = 1; waited <= 60; waited++) begin
         tick;
         if (timeout_err) break;
      end
      chk("t5_timeout_cycle", waited, 41);
      chk("t5_res_valid", res_valid, 1);
      chk("t5_quot", res_quot, 0);
      chk("t5_rem", res_rem, 0);
      chk("t5_hi", hi, 5);
      chk("t5_lo", lo, 32'hFFFF_FFFF);
      consume;
      chk("t5_sticky", timeout_err, 1);
      hang = 0;

      // 6: MTHI on the commit cycle, result held under back-pressure
      lat = 10;
      issue(0, 100, 7);
      for (waited = 0; waited < 60 && !div_complete; waited++) tick;
      chk("t6_complete_seen", div_complete, 1);
      mt_we_hi = 1'b1; mt_wdata = 32'h0000_ABCD;
      tick;
      mt_we_hi = 1'b0;
      chk("t6_res_valid", res_valid, 1);
      chk("t6_hi", hi, 32'h0000_ABCD);
      chk("t6_lo", lo, 14);
      q0 = res_quot; r0 = res_rem;
      chk("t6_quot", q0, 14);
      chk("t6_rem", r0, 2);
      repeat (5) begin
         tick;
         chk("t6_hold_valid", res_valid, 1);
         chk("t6_hold_quot", res_quot, 14);
         chk("t6_hold_rem", res_rem, 2);
      end
      consume;
      chk("t6_released", res_valid, 0);

      // MTLO while idle
      mt_we_lo = 1'b1; mt_wdata = 32'h0000_1234;
      tick;
      mt_we_lo = 1'b0;
      chk("mt_lo", lo, 32'h0000_1234);
      chk("mt_hi_kept", hi, 32'h0000_ABCD);

      // reset mid-operation aborts and clears the sticky flag
      issue(0, 100, 7);
      repeat (3) tick;
      reset = 1'b1;
      tick;
      reset = 1'b0;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_timeout", timeout_err, 0);
      chk("rst_mid_hi", hi, 0);
      chk("rst_mid_lo", lo, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
